// File: rtl/lexington_pkg.sv
// Shared lexington definitions: AXI response codes, bridge state encoding, defaults.
package lexington_pkg;

    localparam int unsigned DEFAULT_AXI_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_AXI_TIMEOUT    = 255;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        BR_IDLE,
        BR_WADDR,
        BR_WRESP,
        BR_RADDR,
        BR_RDATA,
        BR_DONE
    } axi_bridge_state_t;

endpackage

// File: rtl/axi_lite_bridge.sv
// Core data-bus to AXI4-Lite master bridge, single outstanding transaction with response timeout.
module axi_lite_bridge
    import lexington_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_AXI_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      axi_rd_en,
    input  logic                      axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               axi_rd_data,
    output logic                      axi_access_fault,
    output logic                      axi_busy,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    // Counter must be able to hold TIMEOUT_CYCLES itself; keep at least one bit when disabled.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    axi_bridge_state_t         state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic                      aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic [3:0]                wstrb_q, wstrb_d;
    logic                      fault_q, fault_d;
    logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                      arvalid_q, arvalid_d, rready_q, rready_d;
    logic                      timeout, aw_now, w_now;

    // State, counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BR_IDLE;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_data_q <= '0;
            fault_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rd_data_q <= rd_data_d;
            fault_q   <= fault_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rd_data_d = rd_data_q;
        fault_d   = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        cnt_inc   = cnt_q + CNT_W'(1);
        timeout   = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
        aw_now    = aw_done_q | (awvalid_q & m_awready);
        w_now     = w_done_q | (wvalid_q & m_wready);

        unique case (state_q)
            BR_IDLE: begin
                if (axi_wr_en) begin
                    state_d   = BR_WADDR;
                    addr_d    = axi_addr;
                    wdata_d   = wr_data;
                    wstrb_d   = wr_strobe;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end else if (axi_rd_en) begin
                    state_d   = BR_RADDR;
                    addr_d    = axi_addr;
                    arvalid_d = 1'b1;
                end
            end
            BR_WADDR: begin
                aw_done_d = aw_now;
                w_done_d  = w_now;
                if (aw_now && w_now) begin
                    state_d  = BR_WRESP;
                    bready_d = 1'b1;
                end else if (timeout) begin
                    state_d = BR_DONE;
                    fault_d = 1'b1;
                end else begin
                    awvalid_d = ~aw_now;
                    wvalid_d  = ~w_now;
                end
            end
            BR_WRESP: begin
                if (m_bvalid) begin
                    state_d = BR_DONE;
                    fault_d = (axi_resp_t'(m_bresp) != AXI_OKAY);
                end else if (timeout) begin
                    state_d = BR_DONE;
                    fault_d = 1'b1;
                end else begin
                    bready_d = 1'b1;
                end
            end
            BR_RADDR: begin
                if (m_arready) begin
                    state_d  = BR_RDATA;
                    rready_d = 1'b1;
                end else if (timeout) begin
                    state_d = BR_DONE;
                    fault_d = 1'b1;
                end else begin
                    arvalid_d = 1'b1;
                end
            end
            BR_RDATA: begin
                if (m_rvalid) begin
                    state_d   = BR_DONE;
                    rd_data_d = m_rdata;
                    fault_d   = (axi_resp_t'(m_rresp) != AXI_OKAY);
                end else if (timeout) begin
                    state_d = BR_DONE;
                    fault_d = 1'b1;
                end else begin
                    rready_d = 1'b1;
                end
            end
            BR_DONE: state_d = BR_IDLE;
            default: state_d = BR_IDLE;
        endcase

        // Time-in-state restarts on every transition and is idle outside the wait states.
        if ((state_d != state_q) || (state_q == BR_IDLE) || (state_q == BR_DONE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    // Stall the core while a request is being accepted or is in flight.
    always_comb begin
        axi_busy = ((state_q == BR_IDLE) && (axi_rd_en || axi_wr_en)) ||
                   ((state_q != BR_IDLE) && (state_q != BR_DONE));
    end

    assign axi_rd_data      = rd_data_q;
    assign axi_access_fault = fault_q;
    assign m_awaddr         = addr_q;
    assign m_araddr         = addr_q;
    assign m_awprot         = 3'b000;
    assign m_arprot         = 3'b000;
    assign m_awvalid        = awvalid_q;
    assign m_wdata          = wdata_q;
    assign m_wstrb          = wstrb_q;
    assign m_wvalid         = wvalid_q;
    assign m_bready         = bready_q;
    assign m_arvalid        = arvalid_q;
    assign m_rready         = rready_q;

endmodule

// File: tb/tb_axi_lite_bridge.sv
// Self-checking bench for axi_lite_bridge: table vectors, random traffic, timeout and reset corners.
module tb_axi_lite_bridge;
    import lexington_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          axi_rd_en, axi_wr_en;
    logic [AW-1:0] axi_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strobe;
    logic [31:0]   axi_rd_data;
    logic          axi_access_fault, axi_busy;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [2:0]    m_awprot, m_arprot;
    logic          m_awvalid, m_awready, m_wvalid, m_wready;
    logic [31:0]   m_wdata, m_rdata;
    logic [3:0]    m_wstrb;
    logic [1:0]    m_bresp, m_rresp;
    logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    axi_lite_bridge #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .axi_rd_en(axi_rd_en), .axi_wr_en(axi_wr_en), .axi_addr(axi_addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe),
        .axi_rd_data(axi_rd_data), .axi_access_fault(axi_access_fault), .axi_busy(axi_busy),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    // Slave configuration (written by the stimulus only).
    int          cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    logic        mute = 1'b0;
    logic        late_rvalid = 1'b0;
    logic        s_rvalid;

    assign m_rvalid = s_rvalid | late_rvalid;

    // Monitor: handshake counters, captured fields, valid-cycle counts, stability violations.
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_vc = 0, w_vc = 0, ar_vc = 0, proto_err = 0;
    logic [31:0] last_awaddr = '0, last_araddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic        got_aw = 0, got_w = 0, pend_b = 0, pend_r = 0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] p_awaddr = '0, p_araddr = '0, p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    always @(posedge clk) begin
        if (rst) begin
            got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
        end else begin
            if (p_awv && !p_awr && (!m_awvalid || m_awaddr != p_awaddr)) proto_err++;
            if (p_wv && !p_wr && (!m_wvalid || m_wdata != p_wdata || m_wstrb != p_wstrb)) proto_err++;
            if (p_arv && !p_arr && (!m_arvalid || m_araddr != p_araddr)) proto_err++;
            if (m_awvalid) aw_vc++;
            if (m_wvalid) w_vc++;
            if (m_arvalid) ar_vc++;
            if (m_awvalid && m_awready) begin aw_hs++; last_awaddr = m_awaddr; got_aw = 1; end
            if (m_wvalid && m_wready) begin
                w_hs++; last_wdata = m_wdata; last_wstrb = m_wstrb; got_w = 1;
            end
            if (got_aw && got_w) begin pend_b = 1; got_aw = 0; got_w = 0; end
            if (m_bvalid && m_bready) begin b_hs++; pend_b = 0; end
            if (m_arvalid && m_arready) begin ar_hs++; last_araddr = m_araddr; pend_r = 1; end
            if (m_rvalid && m_rready) begin r_hs++; pend_r = 0; end
            p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
            p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata; p_wstrb = m_wstrb;
            p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
        end
    end

    // Slave responder: drives ready/valid on the falling edge with configured wait counts.
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;

    always @(negedge clk) begin
        m_bresp = cfg_resp;
        m_rresp = cfg_resp;
        m_rdata = cfg_rdata;
        if (rst || mute) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; s_rvalid = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        end else begin
            if (m_awvalid) begin m_awready = (aw_wait >= cfg_aw); aw_wait++; end
            else begin m_awready = 0; aw_wait = 0; end
            if (m_wvalid) begin m_wready = (w_wait >= cfg_w); w_wait++; end
            else begin m_wready = 0; w_wait = 0; end
            if (m_arvalid) begin m_arready = (ar_wait >= cfg_ar); ar_wait++; end
            else begin m_arready = 0; ar_wait = 0; end
            if (pend_b) begin m_bvalid = (b_wait >= cfg_b); b_wait++; end
            else begin m_bvalid = 0; b_wait = 0; end
            if (pend_r) begin s_rvalid = (r_wait >= cfg_r); r_wait++; end
            else begin s_rvalid = 0; r_wait = 0; end
        end
    end

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          exp_busy;
        logic        exp_fault;
    } vec_t;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int aw_d, input int w_d, input int b_d,
                                input int ar_d, input int r_d, input logic [1:0] resp,
                                input logic [31:0] rdata, input int exp_busy, input logic exp_fault);
        vec_t v;
        v.is_wr = wr; v.addr = addr; v.data = data; v.strb = strb;
        v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d; v.ar_d = ar_d; v.r_d = r_d;
        v.resp = resp; v.rdata = rdata; v.exp_busy = exp_busy; v.exp_fault = exp_fault;
        return v;
    endfunction

    // Reference: IDLE cycle + one cycle per channel phase plus slave waits; any non-OKAY faults.
    function automatic vec_t model(input vec_t v);
        int slow;
        slow = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
        v.exp_busy  = v.is_wr ? (3 + slow + v.b_d) : (3 + v.ar_d + v.r_d);
        v.exp_fault = (v.resp != 2'b00);
        return v;
    endfunction

    // Count busy cycles until the first non-busy cycle (DONE); releases the request there.
    task automatic wait_done(output int busy, output logic fault, output logic [31:0] rd,
                             output logic done, output logic early);
        busy = 0; done = 0; early = 0; fault = 0; rd = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            #1;
            if (axi_busy) begin
                busy++;
                if (axi_access_fault) early = 1;
                @(negedge clk);
            end else begin
                done = 1; fault = axi_access_fault; rd = axi_rd_data;
                axi_wr_en = 0; axi_rd_en = 0;
            end
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input logic both, input string tag);
        int busy;
        logic fault, done, early;
        logic [31:0] rd;
        int aw0, w0, b0, ar0, r0, awc0, wc0, arc0, pe0;
        @(negedge clk);
        cfg_aw = v.aw_d; cfg_w = v.w_d; cfg_b = v.b_d; cfg_ar = v.ar_d; cfg_r = v.r_d;
        cfg_resp = v.resp; cfg_rdata = v.rdata;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        awc0 = aw_vc; wc0 = w_vc; arc0 = ar_vc; pe0 = proto_err;
        axi_addr = v.addr; wr_data = v.data; wr_strobe = v.strb;
        axi_wr_en = v.is_wr | both;
        axi_rd_en = ~v.is_wr | both;
        wait_done(busy, fault, rd, done, early);
        check({tag, "_busy_cycles"}, 32'(busy), 32'(v.exp_busy));
        check({tag, "_fault_done"}, 32'(fault), 32'(v.exp_fault));
        check({tag, "_fault_before_done"}, 32'(early), 32'd0);
        if (!v.is_wr) check({tag, "_rd_data"}, rd, v.rdata);
        @(negedge clk);
        #1;
        check({tag, "_fault_after_done"}, 32'(axi_access_fault), 32'd0);
        check({tag, "_busy_after_done"}, 32'(axi_busy), 32'd0);
        check({tag, "_stability"}, 32'(proto_err - pe0), 32'd0);
        if (v.is_wr) begin
            check({tag, "_aw_hs"}, 32'(aw_hs - aw0), 32'd1);
            check({tag, "_w_hs"}, 32'(w_hs - w0), 32'd1);
            check({tag, "_b_hs"}, 32'(b_hs - b0), 32'd1);
            check({tag, "_ar_hs"}, 32'(ar_hs - ar0), 32'd0);
            check({tag, "_awaddr"}, last_awaddr, v.addr);
            check({tag, "_wdata"}, last_wdata, v.data);
            check({tag, "_wstrb"}, 32'(last_wstrb), 32'(v.strb));
            check({tag, "_awvalid_cycles"}, 32'(aw_vc - awc0), 32'(v.aw_d + 1));
            check({tag, "_wvalid_cycles"}, 32'(w_vc - wc0), 32'(v.w_d + 1));
        end else begin
            check({tag, "_ar_hs"}, 32'(ar_hs - ar0), 32'd1);
            check({tag, "_r_hs"}, 32'(r_hs - r0), 32'd1);
            check({tag, "_aw_hs"}, 32'(aw_hs - aw0), 32'd0);
            check({tag, "_araddr"}, last_araddr, v.addr);
            check({tag, "_arvalid_cycles"}, 32'(ar_vc - arc0), 32'(v.ar_d + 1));
        end
    endtask

    vec_t tab[7];

    initial begin
        int busy, r0, b0, arc0;
        logic fault, done, early, saw;
        logic [31:0] rd;
        vec_t v;

        tab[0] = mk(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3, 0);
        tab[1] = mk(1, 32'h0000_1008, 32'hCAFE_F00D, 4'b0101, 3, 0, 0, 0, 0, 2'b00, 32'h0, 6, 0);
        tab[2] = mk(0, 32'h0000_2000, 32'h0, 4'b0000, 0, 0, 0, 2, 0, 2'b00, 32'h1234_5678, 5, 0);
        tab[3] = mk(0, 32'h0000_2004, 32'h0, 4'b0000, 0, 0, 0, 0, 0, 2'b10, 32'hA5A5_A5A5, 3, 1);
        tab[4] = mk(1, 32'h0000_1003, 32'h1122_3344, 4'b0010, 1, 2, 1, 0, 0, 2'b11, 32'h0, 6, 1);
        tab[5] = mk(0, 32'h0000_2003, 32'h0, 4'b0000, 0, 0, 0, 0, 3, 2'b01, 32'h0F0F_0F0F, 6, 1);
        tab[6] = mk(1, 32'h0000_100C, 32'h0BAD_CAFE, 4'b1000, 0, 2, 2, 0, 0, 2'b00, 32'h0, 7, 0);

        // Reset state.
        rst = 1; axi_rd_en = 0; axi_wr_en = 0; axi_addr = '0; wr_data = '0; wr_strobe = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_awvalid", 32'(m_awvalid), 0);
        check("rst_wvalid", 32'(m_wvalid), 0);
        check("rst_bready", 32'(m_bready), 0);
        check("rst_arvalid", 32'(m_arvalid), 0);
        check("rst_rready", 32'(m_rready), 0);
        check("rst_awaddr", m_awaddr, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_wdata", m_wdata, 0);
        check("rst_wstrb", 32'(m_wstrb), 0);
        check("rst_rd_data", axi_rd_data, 0);
        check("rst_fault", 32'(axi_access_fault), 0);
        check("rst_busy_idle", 32'(axi_busy), 0);
        axi_rd_en = 1;
        #1 check("rst_busy_follows_req", 32'(axi_busy), 1);
        axi_rd_en = 0;
        #1 check("rst_busy_req_low", 32'(axi_busy), 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 7; i++) run_txn(tab[i], 1'b0, $sformatf("vec%0d", i));

        // rd_en and wr_en together: only the write goes out.
        run_txn(mk(1, 32'h0000_3010, 32'h5555_AAAA, 4'b1111, 0, 0, 0, 0, 0, 2'b00, 32'h0, 3, 0),
                1'b1, "both_req");

        for (int i = 0; i < 30; i++) begin
            v.is_wr = 1'($urandom_range(0, 1));
            v.addr  = $urandom;
            v.data  = $urandom;
            v.strb  = 4'($urandom_range(0, 15));
            v.aw_d  = $urandom_range(0, 4); v.w_d = $urandom_range(0, 4); v.b_d = $urandom_range(0, 4);
            v.ar_d  = $urandom_range(0, 4); v.r_d = $urandom_range(0, 4);
            v.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            v.rdata = $urandom;
            run_txn(model(v), 1'b0, $sformatf("rnd%0d", i));
        end

        // Absent slave: read times out after TO cycles in RADDR, then a late rvalid is ignored.
        @(negedge clk);
        mute = 1; cfg_rdata = 32'hFFFF_0000; cfg_resp = 2'b00;
        arc0 = ar_vc; r0 = r_hs;
        axi_addr = 32'h0000_4000; axi_rd_en = 1;
        wait_done(busy, fault, rd, done, early);
        check("to_busy_cycles", 32'(busy), 32'(1 + TO));
        check("to_fault", 32'(fault), 1);
        check("to_arvalid_in_done", 32'(m_arvalid), 0);
        check("to_arvalid_cycles", 32'(ar_vc - arc0), 32'(TO));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            late_rvalid = 1;
            #1;
            check("late_rready", 32'(m_rready), 0);
            check("late_busy", 32'(axi_busy), 0);
            check("late_fault", 32'(axi_access_fault), 0);
        end
        @(negedge clk);
        late_rvalid = 0; mute = 0;
        check("late_r_hs", 32'(r_hs - r0), 0);

        // Reset while waiting for B, then a normal read.
        @(negedge clk);
        cfg_aw = 0; cfg_w = 0; cfg_b = 5; cfg_resp = 2'b00;
        b0 = b_hs;
        axi_addr = 32'h0000_5000; wr_data = 32'h7777_8888; wr_strobe = 4'hF; axi_wr_en = 1;
        saw = 0;
        for (int c = 0; c < 20 && !saw; c++) begin
            @(negedge clk);
            #1;
            if (m_bready) saw = 1;
        end
        check("rst_wresp_reached", 32'(saw), 1);
        rst = 1;
        #1;
        check("rst_mid_bready", 32'(m_bready), 0);
        check("rst_mid_awvalid", 32'(m_awvalid), 0);
        check("rst_mid_wvalid", 32'(m_wvalid), 0);
        check("rst_mid_arvalid", 32'(m_arvalid), 0);
        check("rst_mid_rready", 32'(m_rready), 0);
        check("rst_mid_awaddr", m_awaddr, 0);
        check("rst_mid_wdata", m_wdata, 0);
        check("rst_mid_fault", 32'(axi_access_fault), 0);
        check("rst_mid_busy_idle_req", 32'(axi_busy), 1);
        axi_wr_en = 0;
        #1 check("rst_mid_busy_idle", 32'(axi_busy), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_mid_b_hs", 32'(b_hs - b0), 0);
        run_txn(mk(0, 32'h0000_2008, 32'h0, 4'b0000, 0, 0, 0, 1, 1, 2'b00, 32'h8765_4321, 5, 0),
                1'b0, "post_rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
